// File: rtl/scroll_pkg.sv
// Shared types and defaults for the pixel scroll controller.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    BRAKE,
    SNAP
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEF_MAX_SCROLL   = 2560;
  localparam int DEF_MAX_SPEED    = 4;
  localparam int DEF_ACCEL_FRAMES = 8;
  localparam int DEF_TILE_BITS    = 5;

endpackage

// File: rtl/scroll_sat_add.sv
// Clamped signed add of the scroll offset with +/- step.
// Landing on a limit with a nonzero step counts as a clamp.
module scroll_sat_add
  import scroll_pkg::*;
#(
  parameter int MAX_SCROLL = DEF_MAX_SCROLL
) (
  input  logic [11:0] scroll_x,
  input  logic [2:0]  step,
  input  logic        dir,
  output logic [11:0] new_x,
  output logic        clamp
);

  localparam logic signed [12:0] LIM = 13'(MAX_SCROLL);

  logic signed [12:0] base;
  logic signed [12:0] delta;
  logic signed [12:0] sum;
  logic               hi;
  logic               lo;

  always_comb begin
    base  = signed'({1'b0, scroll_x});
    delta = signed'({10'd0, step});
    sum   = (dir == DIR_LEFT) ? base - delta
                              : base + delta;
    hi    = sum >= LIM;
    lo    = sum <= 13'sd0;
    clamp = (step != 3'd0) && (hi || lo);
    if (hi)
      new_x = 12'(MAX_SCROLL);
    else if (lo)
      new_x = 12'd0;
    else
      new_x = sum[11:0];
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Frame-tick scroll FSM: move / accelerate / brake, offset register.
// Define SCROLL_SNAP_EN to add a SNAP state that rests on tile edges.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int MAX_SCROLL   = DEF_MAX_SCROLL,
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int TILE_BITS    = DEF_TILE_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  btn_level,
  output logic [11:0] scroll_x,
  output logic [6:0]  map_col,
  output logic [4:0]  fine_x,
  output logic        moving,
  output logic        at_edge
);

  localparam int AW =
    (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [AW-1:0] ACC_LAST =
    AW'(ACCEL_FRAMES - 1);
  localparam logic [2:0]  SPD_TOP = 3'(MAX_SPEED);
  localparam logic [11:0] X_TOP   = 12'(MAX_SCROLL);

  state_t         state_q, st_n, state_d, rest_st;
  logic [2:0]     speed_q, spd_n, speed_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic           dir_q, dir_d;
  logic [11:0]    x_q, x_d;
  logic           clamp;
  logic           dir_only;

`ifdef SCROLL_SNAP_EN
  assign rest_st = (fine_x != 5'd0) ? SNAP : IDLE;
`else
  assign rest_st = IDLE;
`endif

  always_comb begin
    st_n     = state_q;
    spd_n    = speed_q;
    acc_d    = acc_q;
    dir_d    = dir_q;
    dir_only = btn_level ==
      ((dir_q == DIR_LEFT) ? 2'b10 : 2'b01);
    unique case (state_q)
      IDLE: begin
        spd_n = 3'd0;
        unique case (1'b1)
          (btn_level == 2'b01 && x_q != X_TOP): begin
            st_n  = MOVE;
            dir_d = DIR_RIGHT;
            spd_n = 3'd1;
            acc_d = '0;
          end
          (btn_level == 2'b10 && x_q != 12'd0): begin
            st_n  = MOVE;
            dir_d = DIR_LEFT;
            spd_n = 3'd1;
            acc_d = '0;
          end
          default: ;
        endcase
      end
      MOVE: begin
        if (dir_only) begin
          if (acc_q == ACC_LAST) begin
            acc_d = '0;
            if (speed_q != SPD_TOP)
              spd_n = speed_q + 3'd1;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end else begin
          spd_n = speed_q - 3'd1;
          st_n  = (spd_n == 3'd0) ? rest_st : BRAKE;
        end
      end
      BRAKE: begin
        if (dir_only) begin
          st_n  = MOVE;
          acc_d = '0;
        end else begin
          spd_n = speed_q - 3'd1;
          if (spd_n == 3'd0)
            st_n = rest_st;
        end
      end
`ifdef SCROLL_SNAP_EN
      SNAP: spd_n = 3'd1;
`endif
      default: st_n = IDLE;
    endcase
  end

  scroll_sat_add #(
    .MAX_SCROLL(MAX_SCROLL)
  ) u_add (
    .scroll_x(x_q),
    .step    (spd_n),
    .dir     (dir_d),
    .new_x   (x_d),
    .clamp   (clamp)
  );

  // A clamp (or a finished snap) parks the view in IDLE.
  always_comb begin
    state_d = st_n;
    speed_d = spd_n;
    if (clamp) begin
      state_d = IDLE;
      speed_d = 3'd0;
    end
`ifdef SCROLL_SNAP_EN
    else if (state_q == SNAP &&
             x_d[TILE_BITS-1:0] == '0) begin
      state_d = IDLE;
      speed_d = 3'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      speed_q <= 3'd0;
      acc_q   <= '0;
      dir_q   <= DIR_RIGHT;
      x_q     <= 12'd0;
    end else if (frame_tick) begin
      state_q <= state_d;
      speed_q <= speed_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
    end
  end

  assign scroll_x = x_q;
  assign map_col  = 7'(x_q >> TILE_BITS);
  assign fine_x   = 5'(x_q[TILE_BITS-1:0]);
  assign moving   = speed_q != 3'd0;
  assign at_edge  = (x_q == 12'd0) || (x_q == X_TOP);

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Pixel-granular horizontal scroll controller for the tile-map renderer; replaces the per-press, one-block map shift.
- Takes debounced button levels and a once-per-frame tick from the VGA sync.
- Runs a move/accelerate/brake state machine and holds the scroll offset.
- Updates the offset only on frame_tick, so the renderer sees a stable value for a whole frame.

Parameters:
- MAX_SCROLL, 2560, maximum scroll offset in pixels (80 blocks x 32 px).
- MAX_SPEED, 4, maximum speed in px/frame.
- ACCEL_FRAMES, 8, frames spent at each speed before speed increments.
- TILE_BITS, 5, log2 of tile width in pixels.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, asserted at start of vertical blank
- btn_level  in  2  debounced levels; [0]=scroll right (offset up), [1]=scroll left (offset down)
- scroll_x  out  12  current scroll offset in pixels, 0..MAX_SCROLL
- map_col  out  7  scroll_x >> TILE_BITS, block column offset into the map ROM
- fine_x  out  5  scroll_x[TILE_BITS-1:0], sub-tile pixel offset
- moving  out  1  high when speed != 0
- at_edge  out  1  high when scroll_x == 0 or scroll_x == MAX_SCROLL

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: scroll_x=0, speed=0, accel_cnt=0, dir=0, state=IDLE, moving=0, at_edge=1.
- Update timing:
  - All state, speed and scroll registers change only on cycles with frame_tick=1; otherwise they hold.
  - Outputs are registered, or decoded combinationally from registers; they are valid the cycle after the tick.
- Per-tick order: compute next state and speed_next first, then scroll_x += speed_next signed by dir. A move therefore takes effect on the same tick the button is sampled.
- States:
  - IDLE:
    - Exactly one button high → MOVE, dir = that button, speed=1, accel_cnt=0.
    - Both high or neither high → stay IDLE, speed=0.
  - MOVE:
    - Only the dir button high: if accel_cnt==ACCEL_FRAMES-1, speed=min(speed+1, MAX_SPEED) and accel_cnt=0; else accel_cnt++.
    - Any other button combination → BRAKE, speed decrements by 1 on that tick.
  - BRAKE:
    - Each tick speed decrements by 1; reaching 0 → IDLE.
    - Only the dir button high again → MOVE, keeping the current speed, accel_cnt=0.
    - The opposite button is ignored until IDLE is reached.
- Saturation:
  - Arithmetic is 13-bit signed, clamped to [0, MAX_SCROLL].
  - On a clamp, scroll_x equals the limit, speed=0 and state=IDLE on that same tick.
- Boundaries:
  - Pressing left at 0 or right at MAX_SCROLL enters no state; stays IDLE.
  - A reset asserted mid-motion wins over frame_tick in the same cycle.
  - frame_tick held high for several cycles counts as one tick per cycle; sources must pulse it.

Optional Feature:
- Macro: SCROLL_SNAP_EN.
- Defined:
  - BRAKE reaching speed 0 with fine_x != 0 enters SNAP instead of IDLE.
  - SNAP moves 1 px/frame in dir until fine_x==0 or a clamp occurs, then → IDLE.
  - Buttons are ignored in SNAP.
  - Result: the view always rests on a block boundary.
- Undefined: no SNAP state; the view stops at any pixel.

Decomposition:
- Shared package scroll_pkg:
  - state enum (IDLE, MOVE, BRAKE, SNAP).
  - direction constants DIR_RIGHT=0, DIR_LEFT=1.
  - default MAX_SCROLL, MAX_SPEED, ACCEL_FRAMES, TILE_BITS.
- One sub-module, scroll_sat_add: clamped signed add of scroll_x with ±speed_next against 0 and MAX_SCROLL. Outputs are the new offset and a clamp flag.

Test Plan:
- Reset, then 5 frame_ticks with no buttons → scroll_x=0, moving=0, at_edge=1 throughout.
- btn_level=01 held across 9 ticks:
  - after tick 1: scroll_x=1
  - after tick 8: scroll_x=8
  - after tick 9: scroll_x=10, speed 2
- Hold right until speed=3, then release → next two ticks add 2 then 1, then IDLE with moving=0. With SCROLL_SNAP_EN, continues +1/tick until fine_x==0.
- scroll_x=0, btn_level=10 held 4 ticks → scroll_x stays 0, state IDLE, at_edge=1.
- MAX_SCROLL=64, right held → scroll_x saturates at exactly 64 on the clamping tick, moving=0, at_edge=1, map_col=2, fine_x=0.
- Buttons held with no frame_tick for 1000 cycles → no output change. Reset asserted in the same cycle as frame_tick → all outputs return to reset values next cycle.
